// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM stage of the integer pipeline. Takes the EX/MEM entry, performs the
//   data-memory access over a req/ack handshake with variable latency,
//   formats load data, and fills the MEM/WB register consumed by writeback.
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     ex_*                EX/MEM entry (valid, ALU result / effective address,
//                         store data, funct3, read/write, reg_write,
//                         mem_to_reg, rd, next PC)
//     mem_stall           hold EX/MEM and every upstream stage this cycle
//     dmem_req/we/addr/wdata/be   access request towards data memory
//     dmem_ack/rdata      access completion and read word
//     wb_*                MEM/WB register: valid, ALU result, formatted load
//                         data (LMD), rd, qualified reg_write, mem_to_reg,
//                         next PC, exception code (00 none, 01 misaligned or
//                         illegal, 10 timeout)
//
//   Accesses that fault (misaligned, illegal funct3, read+write together)
//   never reach memory: they pass straight to MEM/WB with wb_exc=01.
//   A legal access acknowledged in its first cycle completes without a
//   stall; otherwise the stage stalls in BUSY until ack or until TIMEOUT
//   cycles have elapsed, in which case the request is dropped and the entry
//   retires with wb_exc=10.
module mem_access_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic [DATA_WIDTH-1:0] ex_alu_result,
  input  logic [DATA_WIDTH-1:0] ex_store_data,
  input  logic [2:0]            ex_funct3,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_to_reg,
  input  logic [4:0]            ex_rd,
  input  logic [DATA_WIDTH-1:0] ex_npc,
  output logic                  mem_stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] wb_alu_result,
  output logic [DATA_WIDTH-1:0] wb_lmd,
  output logic [4:0]            wb_rd,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [DATA_WIDTH-1:0] wb_npc,
  output logic [1:0]            wb_exc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_FAULT   = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT = 2'b10;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  // funct3 / direction legality together with natural alignment.
  function automatic logic access_ok(input logic       rd,
                                     input logic       wr,
                                     input logic [2:0] f3,
                                     input logic [1:0] off);
    logic code_ok;
    logic aligned;
    code_ok = 1'b0;
    if (rd && !wr) begin
      code_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                (f3 == F3_BU) || (f3 == F3_HU);
    end else if (wr && !rd) begin
      code_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    case (f3[1:0])
      2'b01:   aligned = !off[0];
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b1;
    endcase
    return code_ok && aligned;
  endfunction

  // Store data is replicated across lanes so memory can pick any lane with be.
  function automatic logic [DATA_WIDTH-1:0] store_wdata(input logic [2:0]            f3,
                                                         input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    case (f3[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [3:0] r;
    case (f3[1:0])
      2'b00:   r = 4'b0001 << off;
      2'b01:   r = off[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // Lane select plus sign/zero extension of the returned word.
  function automatic logic [DATA_WIDTH-1:0] fmt_load(input logic [2:0]            f3,
                                                      input logic [1:0]            off,
                                                      input logic [DATA_WIDTH-1:0] word);
    logic signed [7:0]     b;
    logic signed [15:0]    h;
    logic [DATA_WIDTH-1:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = DATA_WIDTH'(b);             // b is signed: sign-extends
      F3_H:    r = DATA_WIDTH'(h);
      F3_BU:   r = DATA_WIDTH'($unsigned(b));
      F3_HU:   r = DATA_WIDTH'($unsigned(h));
      default: r = word;
    endcase
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  mem_op;
  logic                  op_legal;
  logic                  op_fault;
  logic                  issue;
  logic                  stall;
  logic                  timeout_hit;
  logic                  enter_busy;

  logic [DATA_WIDTH-1:0] st_wdata;
  logic [3:0]            st_be;

  // Request held while BUSY so memory sees a stable access.
  logic [DATA_WIDTH-1:0] req_addr_p1;
  logic [DATA_WIDTH-1:0] req_wdata_p1;
  logic [3:0]            req_be_p1;
  logic                  req_we_p1;
  logic [2:0]            req_f3_p1;

  logic [2:0]            acc_f3;
  logic [1:0]            acc_off;
  logic                  acc_load;
  logic [DATA_WIDTH-1:0] lmd_d;
  logic [1:0]            exc_d;

  assign mem_op   = ex_valid & (ex_mem_read | ex_mem_write);
  assign op_legal = mem_op & access_ok(ex_mem_read, ex_mem_write, ex_funct3,
                                       ex_alu_result[1:0]);
  assign op_fault = mem_op & !op_legal;

  assign st_wdata = ex_mem_write ? store_wdata(ex_funct3, ex_store_data) : '0;
  assign st_be    = ex_mem_write ? store_be(ex_funct3, ex_alu_result[1:0]) : 4'b0000;

  // FSM: state and timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    issue       = 1'b0;
    stall       = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_legal) begin
          issue = 1'b1;
          if (!dmem_ack) begin
            stall   = 1'b1;
            state_d = S_BUSY;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_BUSY: begin
        // The abort cycle drops the request and releases the stall so the
        // faulted entry retires instead of being reissued.
        if (cnt_q == CNT_LIMIT) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
          cnt_d       = '0;
        end else if (dmem_ack) begin
          issue   = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          issue = 1'b1;
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign enter_busy = (state_q == S_IDLE) && (state_d == S_BUSY);

  // Request hold register: loaded on the IDLE->BUSY transition
  always_ff @(posedge clk) begin
    if (enter_busy) begin
      req_addr_p1  <= ex_alu_result;
      req_wdata_p1 <= st_wdata;
      req_be_p1    <= st_be;
      req_we_p1    <= ex_mem_write;
      req_f3_p1    <= ex_funct3;
    end
  end

  // Reset forces the handshake outputs low immediately, even though the
  // upstream stage may still be presenting a memory op.
  assign mem_stall = stall & rst_n;

  always_comb begin
    dmem_req   = issue & rst_n;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_be    = 4'b0000;
    if (dmem_req) begin
      if (state_q == S_BUSY) begin
        dmem_we    = req_we_p1;
        dmem_addr  = req_addr_p1;
        dmem_wdata = req_wdata_p1;
        dmem_be    = req_be_p1;
      end else begin
        dmem_we    = ex_mem_write;
        dmem_addr  = ex_alu_result;
        dmem_wdata = st_wdata;
        dmem_be    = st_be;
      end
    end
  end

  always_comb begin
    acc_f3   = (state_q == S_BUSY) ? req_f3_p1 : ex_funct3;
    acc_off  = (state_q == S_BUSY) ? req_addr_p1[1:0] : ex_alu_result[1:0];
    acc_load = (state_q == S_BUSY) ? !req_we_p1 : (op_legal & ex_mem_read);
    lmd_d    = (acc_load && !timeout_hit) ? fmt_load(acc_f3, acc_off, dmem_rdata) : '0;
    if (timeout_hit) begin
      exc_d = EXC_TIMEOUT;
    end else if ((state_q == S_IDLE) && op_fault) begin
      exc_d = EXC_FAULT;
    end else begin
      exc_d = EXC_NONE;
    end
  end

  // MEM/WB register: a stall cycle inserts a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_alu_result <= '0;
      wb_lmd        <= '0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_npc        <= '0;
      wb_exc        <= EXC_NONE;
    end else if (stall) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid      <= ex_valid;
      wb_alu_result <= ex_alu_result;
      wb_lmd        <= lmd_d;
      wb_rd         <= ex_rd;
      wb_reg_write  <= ex_valid & ex_reg_write & (ex_rd != 5'd0) & (exc_d == EXC_NONE);
      wb_mem_to_reg <= ex_mem_to_reg;
      wb_npc        <= ex_npc;
      wb_exc        <= exc_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed scenarios followed by random
// traffic. Expected MEM/WB entries are queued when an op is driven and a
// separate monitor pops and compares whenever wb_valid is presented.
module tb_mem_access_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [2:0]  ex_funct3;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic [4:0]  ex_rd;
  logic [31:0] ex_npc;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_lmd;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic [31:0] wb_npc;
  logic [1:0]  wb_exc;

  mem_access_stage #(.DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_funct3(ex_funct3), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd),
    .ex_npc(ex_npc), .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_alu_result(wb_alu_result), .wb_lmd(wb_lmd),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_npc(wb_npc), .wb_exc(wb_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] lmd;
    logic [31:0] npc;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic        cmp_lmd;
    logic [1:0]  exc;
  } exp_t;

  typedef struct {
    logic        v;
    logic        ld;
    logic        st;
    logic        rw;
    logic        m2r;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [31:0] npc;
    logic [4:0]  rd;
    int          ack;   // cycle index at which ack arrives, <0 = never
  } txn_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic v, input logic ld, input logic st,
                              input logic rw, input logic m2r, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] rdata, input logic [4:0] rd,
                              input int ack);
    txn_t t;
    t.v = v; t.ld = ld; t.st = st; t.rw = rw; t.m2r = m2r; t.f3 = f3;
    t.addr = addr; t.sdata = sdata; t.rdata = rdata; t.rd = rd; t.ack = ack;
    t.npc = $urandom;
    return t;
  endfunction

  // Drive one EX/MEM entry (called #1 after a posedge), model the expected
  // behaviour from the access rules, and check the handshake cycle by cycle.
  task automatic do_op(input txn_t t);
    exp_t        e;
    bit          is_mem, f3ok, fault, legal, tmo, exp_req;
    int unsigned size, off, lane, stalls, b, h;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;

    is_mem = t.v && (t.ld || t.st);
    if (t.ld && t.st)  f3ok = 1'b0;
    else if (t.ld)     f3ok = (t.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else               f3ok = (t.f3 inside {3'd0, 3'd1, 3'd2});
    size   = 1 << (t.f3 % 4);
    off    = t.addr % 4;
    fault  = is_mem && (!f3ok || (t.addr % size) != 0);
    legal  = is_mem && !fault;
    tmo    = legal && (t.ack < 0 || t.ack >= TO);
    stalls = !legal ? 0 : (tmo ? TO : t.ack);

    lane = t.rdata >> (8 * off);
    b    = lane % 256;
    h    = lane % 65536;
    e.alu = t.addr;
    e.npc = t.npc;
    e.rd  = t.rd;
    e.m2r = t.m2r;
    e.exc = fault ? 2'd1 : (tmo ? 2'd2 : 2'd0);
    e.rw  = t.rw && (t.rd != 0) && (e.exc == 2'd0);
    e.cmp_lmd = legal && !tmo;
    if (t.st) e.lmd = 32'd0;
    else begin
      case (t.f3)
        3'd0:    e.lmd = (b >= 128) ? b + 32'hFFFF_FF00 : b;
        3'd1:    e.lmd = (h >= 32768) ? h + 32'hFFFF_0000 : h;
        3'd4:    e.lmd = b;
        3'd5:    e.lmd = h;
        default: e.lmd = t.rdata;
      endcase
    end
    if (size == 1)      exp_wdata = (t.sdata % 256) * 32'h0101_0101;
    else if (size == 2) exp_wdata = (t.sdata % 65536) * 32'h0001_0001;
    else                exp_wdata = t.sdata;
    exp_be = t.st ? 4'(((1 << size) - 1) << off) : 4'b0000;

    ex_valid      = t.v;
    ex_mem_read   = t.ld;
    ex_mem_write  = t.st;
    ex_reg_write  = t.rw;
    ex_mem_to_reg = t.m2r;
    ex_funct3     = t.f3;
    ex_alu_result = t.addr;
    ex_store_data = t.sdata;
    ex_rd         = t.rd;
    ex_npc        = t.npc;
    dmem_rdata    = t.rdata;
    dmem_ack      = legal && (t.ack == 0);
    if (t.v) sb.push_back(e);

    for (int c = 0; c <= int'(stalls); c++) begin
      @(negedge clk);
      chk("mem_stall", 32'(mem_stall), 32'(c < int'(stalls)));
      exp_req = legal && !(tmo && c == TO);
      chk("dmem_req", 32'(dmem_req), 32'(exp_req));
      if (exp_req) begin
        chk("dmem_addr", dmem_addr, t.addr);
        chk("dmem_we", 32'(dmem_we), 32'(t.st));
        chk("dmem_be", 32'(dmem_be), 32'(exp_be));
        if (t.st) chk("dmem_wdata", dmem_wdata, exp_wdata);
      end
      if (c > 0) chk("wb_bubble", 32'(wb_valid), 32'd0);
      @(posedge clk);
      #1;
      dmem_ack = legal && (c + 1 == t.ack);
    end
    dmem_ack = 1'b0;
  endtask

  // Monitor: every presented MEM/WB entry must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && wb_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wb_unexpected: got wb_valid=1, expected no entry pending (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("wb_alu_result", wb_alu_result, e.alu);
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
          chk("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(e.m2r));
          chk("wb_npc", wb_npc, e.npc);
          chk("wb_exc", 32'(wb_exc), 32'(e.exc));
          if (e.cmp_lmd) chk("wb_lmd", wb_lmd, e.lmd);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  logic [2:0] ld_codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    txn_t t;
    rst_n = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    // A legal load is presented during reset: outputs must still be quiet.
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = 3'b010;
    ex_alu_result = 32'h100; ex_store_data = 32'h0; ex_reg_write = 1'b1;
    ex_mem_to_reg = 1'b1; ex_rd = 5'd3; ex_npc = 32'h4;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_mem_stall", 32'(mem_stall), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_dmem_be", 32'(dmem_be), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("rst_wb_exc", 32'(wb_exc), 32'd0);
    chk("rst_wb_lmd", wb_lmd, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ex_valid = 1'b0;

    // Directed scenarios
    do_op(mk(1, 1, 0, 1, 1, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 5'd5, 0));   // LW, same-cycle ack
    do_op(mk(1, 1, 0, 1, 1, 3'b000, 32'h103, 32'h0, 32'h8012_3456, 5'd6, 3));   // LB, 3-cycle wait
    do_op(mk(1, 1, 0, 1, 1, 3'b100, 32'h103, 32'h0, 32'h8012_3456, 5'd6, 3));   // LBU
    do_op(mk(1, 0, 1, 0, 0, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 5'd0, 1));   // SH upper half
    do_op(mk(1, 1, 0, 1, 1, 3'b010, 32'h101, 32'h0, 32'h1234_5678, 5'd7, 0));   // misaligned LW
    do_op(mk(1, 1, 0, 1, 1, 3'b011, 32'h100, 32'h0, 32'h1234_5678, 5'd7, 0));   // illegal funct3
    do_op(mk(1, 1, 1, 1, 1, 3'b010, 32'h100, 32'h0, 32'h1234_5678, 5'd7, 0));   // read+write
    do_op(mk(1, 1, 0, 1, 1, 3'b010, 32'h180, 32'h0, 32'h1111_2222, 5'd8, -1));  // timeout
    do_op(mk(1, 1, 0, 1, 1, 3'b001, 32'h186, 32'h0, 32'h8001_7FFF, 5'd9, TO));  // ack too late
    do_op(mk(1, 1, 0, 1, 1, 3'b101, 32'h186, 32'h0, 32'h8001_7FFF, 5'd9, TO - 1)); // last chance
    do_op(mk(1, 0, 0, 1, 0, 3'b000, 32'h0000_0042, 32'h0, 32'h0, 5'd0, 0));    // ADD rd=0
    do_op(mk(1, 0, 0, 1, 0, 3'b000, 32'h0000_0043, 32'h0, 32'h0, 5'd12, 0));   // ADD rd=12

    // Stray ack while idle with nothing outstanding is ignored.
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("stray_ack_req", 32'(dmem_req), 32'd0);
    chk("stray_ack_stall", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1 dmem_ack = 1'b0;

    // Reset while BUSY: handshake drops at once, next access is clean.
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = 3'b010;
    ex_alu_result = 32'h300; ex_reg_write = 1'b1; ex_rd = 5'd4;
    repeat (3) @(posedge clk);
    #2;
    chk("busy_req_before_rst", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("busy_rst_req", 32'(dmem_req), 32'd0);
    chk("busy_rst_stall", 32'(mem_stall), 32'd0);
    chk("busy_rst_wb_valid", 32'(wb_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_op(mk(1, 1, 0, 1, 1, 3'b010, 32'h104, 32'h0, 32'hCAFE_F00D, 5'd10, 1));

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      int kind, r;
      kind = $urandom_range(0, 9);
      t = mk(($urandom_range(0, 9) != 0), 1'b0, 1'b0, 1'($urandom), 1'($urandom),
             3'($urandom), $urandom, $urandom, $urandom, 5'($urandom), 0);
      if (kind < 4)       t.ld = 1'b1;
      else if (kind < 7)  t.st = 1'b1;
      else if (kind == 9) begin t.ld = 1'b1; t.st = 1'b1; end
      if ($urandom_range(0, 3) != 0) begin
        t.f3 = t.st ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
        if ($urandom_range(0, 4) != 0)
          t.addr = t.addr & ~((32'd1 << (t.f3 % 4)) - 32'd1);
      end
      r = $urandom_range(0, 19);
      if (r == 19)      t.ack = -1;
      else if (r == 18) t.ack = TO;
      else if (r == 17) t.ack = TO - 1;
      else              t.ack = r % 5;
      do_op(t);
    end

    // Drain: everything issued must have retired.
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
